// File: rtl/router_in_port_pkg.sv
// router_in_port_pkg: packet type, receive-FSM states and packet helpers shared by the
// router input port and its packet FIFO.
package router_in_port_pkg;

    // Bytes per serial packet: one header byte {src,dest} followed by three data bytes.
    localparam int PKT_BYTES = 4;

    typedef logic [1:0] byte_idx_t;

    // Index of the final data byte; the packet is complete when this byte is sampled.
    localparam byte_idx_t LAST_IDX = byte_idx_t'(PKT_BYTES - 1);

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

    // Build a packet from the header byte and the three assembled data bytes.
    function automatic pkt_t make_pkt(input logic [7:0] hdr, input logic [23:0] data);
        pkt_t p;
        p.src  = hdr[7:4];
        p.dest = hdr[3:0];
        p.data = data;
        return p;
    endfunction

endpackage

// File: rtl/router_in_port_fifo.sv
// pkt_fifo: whole-packet FIFO for the router input port. Registered storage, combinational
// head read. Push and pop on the same edge are both honoured. Pointers wrap modulo DEPTH
// (DEPTH must be a power of two).
module pkt_fifo
    import router_in_port_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pkt_t
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  T                      push_data_i,
    input  logic                  pop_i,
    output T                      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned
        // (otherwise synthesis infers a latch).
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of block ordering.
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Packet storage.
    always_ff @(posedge clock_i) begin
        // NOTE: storage is deliberately not reset; the pointers define which entries are
        // live, and the head read below is forced to zero while empty.
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head read: zero while empty so stale or uninitialised entries never reach the port.
    always_comb begin
        head_o = '0;
        if (!empty_o) head_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/router_in_port.sv
// router_in_port: router-side receive port for one node link. Reassembles the 4-byte
// put/payload stream into packets, buffers whole packets in pkt_fifo and offers the head
// packet to the switch over out_valid/out_ready.
// Optional statistics (pkt_count, drop_count) are built when ROUTER_IN_STATS_EN is defined.
module router_in_port
    import router_in_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             put_inbound,
    input  logic [7:0]       payload_inbound,
    output logic             free_inbound,
    output logic [31:0]      out_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_abort
`ifdef ROUTER_IN_STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // Reject unusable configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("router_in_port: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    rx_state_t     state_q;
    byte_idx_t     idx_q;
    logic [7:0]    hdr_q;
    logic [15:0]   data_hi_q;
    logic          err_abort_q;

    pkt_t          fifo_head;
    pkt_t          push_pkt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;

    logic          recv_last;
    logic          abort_evt;
    logic          drop_entry;

    // A new packet may start only from IDLE with room for a whole packet. The count is the
    // registered one, so a pop on this edge re-opens the port only from the next cycle.
    assign free_inbound = ~reset & (state_q == RX_IDLE) & (fifo_count < DEPTH_CNT);

    assign recv_last  = (state_q == RX_RECV) & put_inbound & (idx_q == LAST_IDX);
    assign abort_evt  = (state_q == RX_RECV) & ~put_inbound;
    assign drop_entry = (state_q == RX_IDLE) & put_inbound & ~free_inbound;

    // The last byte goes straight into the FIFO alongside the registered header and upper
    // data bytes. A packet only starts with room available, so full never blocks here; the
    // guard just keeps the FIFO safe.
    assign push_pkt = make_pkt(hdr_q, {data_hi_q, payload_inbound});
    assign push     = recv_last & ~fifo_full;
    assign pop      = out_ready;

    // Receive FSM: frames header and data bytes, flags aborted packets, skips overruns.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            idx_q       <= '0;
            hdr_q       <= '0;
            data_hi_q   <= '0;
            err_abort_q <= 1'b0;
        end else begin
            err_abort_q <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (put_inbound) begin
                        if (free_inbound) begin
                            hdr_q   <= payload_inbound;
                            idx_q   <= 2'd1;
                            state_q <= RX_RECV;
                        end else begin
                            state_q <= RX_DROP;
                        end
                    end
                end
                RX_RECV: begin
                    if (put_inbound) begin
                        case (idx_q)
                            2'd1:    data_hi_q[15:8] <= payload_inbound;
                            2'd2:    data_hi_q[7:0]  <= payload_inbound;
                            default: ;
                        endcase
                        if (recv_last) begin
                            state_q <= RX_IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else begin
                        err_abort_q <= 1'b1;
                        state_q     <= RX_IDLE;
                    end
                end
                RX_DROP: begin
                    if (!put_inbound) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    pkt_fifo #(
        .DEPTH (DEPTH),
        .T     (pkt_t)
    ) u_fifo (
        .clock_i     (clock),
        .reset_i     (reset),
        .push_i      (push),
        .push_data_i (push_pkt),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign out_pkt   = fifo_head;
    assign out_valid = ~fifo_empty;
    assign err_abort = err_abort_q;

`ifdef ROUTER_IN_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    // Saturating counters: packets enqueued, and packets aborted or skipped while full.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (push && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 1'b1;
        if ((abort_evt || drop_entry) && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule
